scan_test_ctrl: RTL and testbench

- Tester-side scan-chain controller that drives the scan interface of a scan-inserted datapath block, such as the scan-enabled 4-bit adder with its 5-bit sum chain.
- Per test it shifts a stimulus pattern in through scan_in, pulses one functional capture cycle, then shifts the chain out of scan_out.
- Compares the unloaded response against an expected value under a mask.
- Sits between a pattern source (bench or BIST sequencer) and the scan port of the block under test.

---
 rtl/scan_pkg.sv | 11 +
 rtl/scan_shift_reg.sv | 32 +++
 rtl/scan_test_ctrl.sv | 154 +++++++++++++++
 tb/tb_scan_test_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared state encoding and default geometry for the scan test controller.
package scan_pkg;
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
   localparam logic [2:0] ST_CAPTURE   = 3'd2;
   localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   localparam int   CHAIN_LEN_DEF = 5;
   localparam logic FILL_BIT_DEF  = 1'b0;
endpackage

// File: rtl/scan_shift_reg.sv
// Right-shifting register with parallel load; serial data enters at the MSB
// and leaves at the LSB.
module scan_shift_reg #(
   parameter int WIDTH = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_shift,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_next,
   output logic             o_sout
);
   logic [WIDTH-1:0] r_q;

   // o_next is the post-shift value, so callers can act on it in the same edge.
   assign o_next = (r_q >> 1) | (WIDTH'(i_sin) << (WIDTH - 1));
   assign o_q    = r_q;
   assign o_sout = r_q[0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_shift) begin
         r_q <= o_next;
      end
   end
endmodule

// File: rtl/scan_test_ctrl.sv
// Tester-side scan controller: shift a stimulus in, pulse one capture cycle,
// unload the chain and compare it against an expected value under a mask.
module scan_test_ctrl
   import scan_pkg::*;
#(
   parameter int   CHAIN_LEN = CHAIN_LEN_DEF,
   parameter logic FILL_BIT  = FILL_BIT_DEF
) (
   input  logic                 CK,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern_in,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic [CHAIN_LEN-1:0] mask,
   output logic                 scan_enable,
   output logic                 scan_in,
   input  logic                 scan_out,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic                 pass
);
   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   logic [2:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [CHAIN_LEN-1:0] r_exp;
   logic [CHAIN_LEN-1:0] r_mask;
   logic                 r_scan_en;
   logic                 r_scan_in;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;

   logic                 w_accept;
   logic                 w_cnt_last;
   logic [CHAIN_LEN-1:0] w_stim_q;
   logic [CHAIN_LEN-1:0] w_stim_next;
   logic                 w_stim_sout;
   logic [CHAIN_LEN-1:0] w_resp_q;
   logic [CHAIN_LEN-1:0] w_resp_next;
   logic                 w_resp_sout;
   logic                 w_unused;

   assign w_accept   = (r_state == ST_IDLE) && start;
   assign w_cnt_last = (r_cnt == CNT_W'(CHAIN_LEN - 1));
   assign w_unused   = ^{w_stim_q, w_stim_next, w_resp_sout};

   // Bit 0 goes straight to scan_in on acceptance, so the stimulus register
   // only has to hold the remaining bits.
   scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
      .i_clk      (CK),
      .i_rst      (rst),
      .i_load     (w_accept),
      .i_load_val (pattern_in >> 1),
      .i_shift    (r_state == ST_SHIFT_IN),
      .i_sin      (1'b0),
      .o_q        (w_stim_q),
      .o_next     (w_stim_next),
      .o_sout     (w_stim_sout)
   );

   scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
      .i_clk      (CK),
      .i_rst      (rst),
      .i_load     (w_accept),
      .i_load_val ('0),
      .i_shift    (r_state == ST_SHIFT_OUT),
      .i_sin      (scan_out),
      .o_q        (w_resp_q),
      .o_next     (w_resp_next),
      .o_sout     (w_resp_sout)
   );

   always_ff @(posedge CK or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_exp     <= '0;
         r_mask    <= '0;
         r_scan_en <= 1'b0;
         r_scan_in <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_scan_en <= 1'b0;
               r_scan_in <= 1'b0;
               if (start) begin
                  r_state   <= ST_SHIFT_IN;
                  r_cnt     <= '0;
                  r_exp     <= expected;
                  r_mask    <= mask;
                  r_scan_en <= 1'b1;
                  r_scan_in <= pattern_in[0];
                  r_busy    <= 1'b1;
                  r_pass    <= 1'b0;
               end
            end
            ST_SHIFT_IN: begin
               if (w_cnt_last) begin
                  r_state   <= ST_CAPTURE;
                  r_cnt     <= '0;
                  r_scan_en <= 1'b0;
                  r_scan_in <= 1'b0;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_scan_in <= w_stim_sout;
               end
            end
            ST_CAPTURE: begin
               r_state   <= ST_SHIFT_OUT;
               r_cnt     <= '0;
               r_scan_en <= 1'b1;
               r_scan_in <= FILL_BIT;
            end
            ST_SHIFT_OUT: begin
               if (w_cnt_last) begin
                  // Judge the response including the bit sampled on this edge.
                  r_state   <= ST_DONE;
                  r_cnt     <= '0;
                  r_scan_en <= 1'b0;
                  r_scan_in <= 1'b0;
                  r_done    <= 1'b1;
                  r_pass    <= ~|((w_resp_next ^ r_exp) & r_mask);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_scan_en <= 1'b0;
               r_scan_in <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign scan_enable = r_scan_en;
   assign scan_in     = r_scan_in;
   assign busy        = r_busy;
   assign done        = r_done;
   assign response    = w_resp_q;
   assign pass        = r_pass;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl driving a behavioural 5-bit sum scan chain.
module tb_scan_test_ctrl;
   logic       CK;
   logic       rst;
   logic       start;
   logic [4:0] pattern_in;
   logic [4:0] expected;
   logic [4:0] mask;
   logic       scan_enable;
   logic       scan_in;
   logic       scan_out;
   logic       busy;
   logic       done;
   logic [4:0] response;
   logic       pass;

   logic [4:0] tb_chain;
   logic [4:0] tb_sum;
   int         n_tests = 0;
   int         n_fail  = 0;

   scan_test_ctrl #(.CHAIN_LEN(5), .FILL_BIT(1'b0)) dut (
      .CK          (CK),
      .rst         (rst),
      .start       (start),
      .pattern_in  (pattern_in),
      .expected    (expected),
      .mask        (mask),
      .scan_enable (scan_enable),
      .scan_in     (scan_in),
      .scan_out    (scan_out),
      .busy        (busy),
      .done        (done),
      .response    (response),
      .pass        (pass)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Scan-inserted adder model: functional mode captures the sum, scan mode
   // shifts towards the tail at bit 0.
   always @(posedge CK) begin
      if (scan_enable) tb_chain <= {scan_in, tb_chain[4:1]};
      else             tb_chain <= tb_sum;
   end
   assign scan_out = tb_chain[0];

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic run_test(input string tag, input logic [4:0] pat, input logic [4:0] exp_v,
                           input logic [4:0] msk, input logic [4:0] sum, input logic exp_pass,
                           input bit busy_poke);
      int dones;
      pattern_in = pat; expected = exp_v; mask = msk; tb_sum = sum; start = 1'b1;
      tick();
      start = 1'b0; pattern_in = ~pat; expected = ~exp_v; mask = ~msk;
      for (int i = 0; i < 5; i++) begin
         chk({tag, "_shin_se"}, scan_enable, 1);
         chk({tag, "_shin_si"}, scan_in, pat[i]);
         chk({tag, "_shin_busy"}, busy, 1);
         start = (busy_poke && i == 2) ? 1'b1 : 1'b0;
         tick();
      end
      start = 1'b0;
      chk({tag, "_cap_se"}, scan_enable, 0);
      chk({tag, "_cap_si"}, scan_in, 0);
      chk({tag, "_cap_chain"}, tb_chain, pat);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk({tag, "_shout_se"}, scan_enable, 1);
         chk({tag, "_shout_si"}, scan_in, 0);
         chk({tag, "_shout_done"}, done, 0);
         tick();
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_resp"}, response, sum);
      chk({tag, "_pass"}, pass, exp_pass);
      chk({tag, "_done_se"}, scan_enable, 0);
      tick();
      chk({tag, "_idle_done"}, done, 0);
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_pass"}, pass, exp_pass);
      if (busy_poke) begin
         dones = 0;
         for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            tick();
         end
         chk({tag, "_no_extra_run"}, dones, 0);
         chk({tag, "_resp_hold"}, response, sum);
      end
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; pattern_in = '0; expected = '0; mask = '0; tb_sum = '0;
      tick();
      tick();
      chk("rst_se", scan_enable, 0);
      chk("rst_si", scan_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_resp", response, 5'b00000);
      rst = 1'b0;
      tick();

      run_test("pass7p8", 5'b10110, 5'b01111, 5'b11111, 5'b01111, 1'b1, 1'b0);
      run_test("miss3p5", 5'b01001, 5'b01111, 5'b11111, 5'b01000, 1'b0, 1'b0);
      run_test("mask3p5", 5'b11100, 5'b01111, 5'b10000, 5'b01000, 1'b1, 1'b0);
      run_test("busyrej", 5'b11001, 5'b10010, 5'b11111, 5'b10010, 1'b1, 1'b1);

      // Abort in the second unload cycle.
      pattern_in = 5'b10101; expected = 5'b01111; mask = 5'b11111; tb_sum = 5'b01111;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("abort_pre_se", scan_enable, 1);
      chk("abort_pre_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_se", scan_enable, 0);
      chk("abort_si", scan_in, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_pass", pass, 0);
      chk("abort_resp", response, 5'b00000);
      tick();
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dones++;
         tick();
      end
      chk("abort_no_done", dones, 0);

      run_test("after_abort", 5'b00111, 5'b10001, 5'b11111, 5'b10001, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
